// File: rtl/tdm_pkg.sv
// Shared constants and types for the 8-slot TDM receive path.
package tdm_pkg;

   localparam int N_SLOTS   = 8;
   localparam int SLOT_W    = 3;
   localparam int ERR_LIMIT = 3;
   localparam int ERR_W     = 2;

   typedef enum logic {
      HUNT = 1'b0,
      RECV = 1'b1
   } state_t;

   function automatic logic is_last_slot(input logic [SLOT_W-1:0] slot);
      return slot == SLOT_W'(N_SLOTS - 1);
   endfunction

endpackage

// File: rtl/slot_counter_mod8.sv
// Slot index counter: wraps 7 -> 0, can jump straight to 1 when a slot-0 sample is taken.
module slot_counter_mod8
   import tdm_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              load_one,
   input  logic              clear,
   output logic [SLOT_W-1:0] cnt,
   output logic              wrap
);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (load_one) begin
         cnt <= SLOT_W'(1);
      end else if (en) begin
         cnt <= cnt + 1'b1;
      end
   end

   assign wrap = is_last_slot(cnt);

endmodule

// File: rtl/tdm_demux_1a8.sv
// 8-slot TDM demultiplexer: gathers one frame in a shadow register and publishes it whole.
//
//   state | meaning
//   HUNT  | unlocked; drop samples until one arrives flagged as slot 0
//   RECV  | locked; each accepted sample fills the slot pointed to by sel
module tdm_demux_1a8
   import tdm_pkg::*;
#(
   parameter int DW = 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [DW-1:0]         din,
   input  logic                  din_valid,
   input  logic                  frame_start,
   output logic [SLOT_W-1:0]     sel,
   output logic [N_SLOTS*DW-1:0] dout,
   output logic                  frame_valid,
   output logic                  sync_err,
   output logic                  locked
);

   state_t                      state, state_nxt;
   logic [SLOT_W-1:0]           sel_cnt;
   logic                        last_slot;
   logic [ERR_W-1:0]            err_cnt, err_cnt_nxt;
   logic [(N_SLOTS-1)*DW-1:0]   shadow;

   logic                        cnt_en;
   logic                        cnt_load;
   logic                        cnt_clear;
   logic                        shadow_we;
   logic [SLOT_W-1:0]           shadow_idx;
   logic                        publish;
   logic                        resync;

   slot_counter_mod8 u_slot_cnt (
      .clk      (clk),
      .rst_n    (rst_n),
      .en       (cnt_en),
      .load_one (cnt_load),
      .clear    (cnt_clear),
      .cnt      (sel_cnt),
      .wrap     (last_slot)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= HUNT;
         err_cnt <= '0;
      end else begin
         state   <= state_nxt;
         err_cnt <= err_cnt_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      err_cnt_nxt = err_cnt;
      cnt_en      = 1'b0;
      cnt_load    = 1'b0;
      cnt_clear   = 1'b0;
      shadow_we   = 1'b0;
      publish     = 1'b0;
      resync      = 1'b0;
      case (state)
         HUNT: begin
            if (din_valid && frame_start) begin
               shadow_we = 1'b1;
               cnt_load  = 1'b1;
               state_nxt = RECV;
            end
         end
         RECV: begin
            if (din_valid) begin
               // A slot-0 marker anywhere but slot 0 (including slot 7) is a resync.
               if (frame_start && (sel_cnt != '0)) begin
                  resync = 1'b1;
                  if (err_cnt == ERR_W'(ERR_LIMIT - 1)) begin
                     state_nxt   = HUNT;
                     cnt_clear   = 1'b1;
                     err_cnt_nxt = '0;
                  end else begin
                     err_cnt_nxt = err_cnt + 1'b1;
                     shadow_we   = 1'b1;
                     cnt_load    = 1'b1;
                  end
               end else if (last_slot) begin
                  publish     = 1'b1;
                  cnt_en      = 1'b1;
                  err_cnt_nxt = '0;
               end else begin
                  shadow_we = 1'b1;
                  cnt_en    = 1'b1;
               end
            end
         end
         default: state_nxt = HUNT;
      endcase
   end

   // Slot-0 loads always target shadow slot 0 regardless of where sel was.
   assign shadow_idx = cnt_load ? '0 : sel_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         shadow <= '0;
      end else begin
         for (int k = 0; k < N_SLOTS - 1; k++) begin
            if (shadow_we && (shadow_idx == SLOT_W'(k))) begin
               shadow[k*DW +: DW] <= din;
            end
         end
      end
   end

   // Slot 7 bypasses the shadow so the whole frame lands in dout on one edge.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         dout        <= '0;
         frame_valid <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         if (publish) begin
            dout <= {din, shadow};
         end
         frame_valid <= publish;
         sync_err    <= resync;
      end
   end

   assign sel    = sel_cnt;
   assign locked = (state == RECV);

endmodule

// File: tb/tb_tdm_demux_1a8.sv
// Directed bench for tdm_demux_1a8 with a queue-based scoreboard for frame and sync-error pulses.
module tb_tdm_demux_1a8;

   logic       clk;
   logic       rst_n;
   logic [0:0] din;
   logic       din_valid;
   logic       frame_start;
   logic [2:0] sel;
   logic [7:0] dout;
   logic       frame_valid;
   logic       sync_err;
   logic       locked;

   int n_total = 0;
   int n_pass  = 0;

   logic [7:0] fv_q[$];
   logic [7:0] se_q[$];

   tdm_demux_1a8 #(.DW(1)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .din         (din),
      .din_valid   (din_valid),
      .frame_start (frame_start),
      .sel         (sel),
      .dout        (dout),
      .frame_valid (frame_valid),
      .sync_err    (sync_err),
      .locked      (locked)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   // Monitor: every frame_valid / sync_err pulse must match a queued expectation.
   always @(negedge clk) begin
      if (frame_valid === 1'b1) begin
         if (fv_q.size() == 0) begin
            n_total++;
            $display("FAIL frame_valid_unexpected: got pulse dout=%0h expected no pulse at %0t",
                     dout, $time);
         end else begin
            chk("frame_dout", 32'(dout), 32'(fv_q.pop_front()));
         end
      end
      if (sync_err === 1'b1) begin
         if (se_q.size() == 0) begin
            n_total++;
            $display("FAIL sync_err_unexpected: got pulse expected no pulse at %0t", $time);
         end else begin
            chk("sync_err_dout_held", 32'(dout), 32'(se_q.pop_front()));
            chk("sync_err_no_frame_valid", 32'(frame_valid), 32'd0);
         end
      end
   end

   task automatic cyc(input logic v, input logic fs, input logic d);
      din_valid   = v;
      frame_start = fs;
      din         = d;
      @(posedge clk);
      #1;
   endtask

   task automatic send_partial(input logic [7:0] b, input int n);
      for (int k = 0; k < n; k++) begin
         cyc(1'b1, (k == 0), b[k]);
         chk("partial_sel", 32'(sel), 32'(k + 1));
      end
      din_valid = 1'b0;
   endtask

   task automatic send_frame(input logic [7:0] b, input int stall_after, input int stall_n,
                             input logic [7:0] hold_dout);
      for (int k = 0; k < 8; k++) begin
         if (k == 7) fv_q.push_back(b);
         cyc(1'b1, (k == 0), b[k]);
         chk("frame_sel", 32'(sel), 32'((k + 1) % 8));
         if (k == stall_after) begin
            for (int s = 0; s < stall_n; s++) begin
               cyc(1'b0, 1'b1, 1'b1);
               chk("stall_sel", 32'(sel), 32'(k + 1));
               chk("stall_dout", 32'(dout), 32'(hold_dout));
            end
         end
      end
      din_valid = 1'b0;
   endtask

   initial begin
      rst_n       = 1'b0;
      din         = '0;
      din_valid   = 1'b0;
      frame_start = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_dout", 32'(dout), 32'h0);
      chk("rst_sel", 32'(sel), 32'h0);
      chk("rst_locked", 32'(locked), 32'h0);
      chk("rst_frame_valid", 32'(frame_valid), 32'h0);
      chk("rst_sync_err", 32'(sync_err), 32'h0);
      rst_n = 1'b1;
      cyc(1'b0, 1'b0, 1'b0);

      // HUNT drops unmarked samples
      for (int i = 0; i < 3; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         chk("hunt_sel", 32'(sel), 32'h0);
         chk("hunt_locked", 32'(locked), 32'h0);
      end

      // Frame A5, then idle
      send_frame(8'hA5, -1, 0, 8'h00);
      chk("a5_locked", 32'(locked), 32'h1);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      chk("a5_dout", 32'(dout), 32'hA5);

      // Stall 3 cycles after slot 3 (frame_start during stall must be ignored)
      send_frame(8'h96, 3, 3, 8'hA5);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      chk("stall_final_dout", 32'(dout), 32'h96);

      // Resync at sel=5: partial frame discarded, new frame completes
      send_partial(8'hFF, 5);
      chk("pre_resync_sel", 32'(sel), 32'h5);
      se_q.push_back(8'h96);
      send_frame(8'h71, -1, 0, 8'h00);
      repeat (2) cyc(1'b0, 1'b0, 1'b0);
      chk("resync_dout", 32'(dout), 32'h71);
      chk("resync_locked", 32'(locked), 32'h1);

      // Lock loss after three resyncs without a completed frame
      send_partial(8'h0F, 3);
      se_q.push_back(8'h71);
      send_partial(8'h01, 2);
      se_q.push_back(8'h71);
      send_partial(8'h01, 2);
      chk("pre_loss_locked", 32'(locked), 32'h1);
      se_q.push_back(8'h71);
      cyc(1'b1, 1'b1, 1'b1);
      din_valid = 1'b0;
      chk("loss_sel", 32'(sel), 32'h0);
      chk("loss_locked", 32'(locked), 32'h0);
      for (int i = 0; i < 4; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         chk("loss_hunt_sel", 32'(sel), 32'h0);
         chk("loss_hunt_locked", 32'(locked), 32'h0);
      end
      chk("loss_dout", 32'(dout), 32'h71);

      // Async reset between edges at sel=4
      send_partial(8'hAA, 4);
      chk("pre_reset_sel", 32'(sel), 32'h4);
      #2 rst_n = 1'b0;
      #1;
      chk("async_rst_dout", 32'(dout), 32'h0);
      chk("async_rst_sel", 32'(sel), 32'h0);
      chk("async_rst_locked", 32'(locked), 32'h0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 2; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
         chk("post_rst_sel", 32'(sel), 32'h0);
         chk("post_rst_locked", 32'(locked), 32'h0);
      end

      // Back-to-back frames
      send_frame(8'h3C, -1, 0, 8'h00);
      send_frame(8'hC3, -1, 0, 8'h00);
      repeat (3) cyc(1'b0, 1'b0, 1'b0);
      chk("b2b_dout", 32'(dout), 32'hC3);
      chk("b2b_locked", 32'(locked), 32'h1);
      chk("fv_queue_drained", 32'(fv_q.size()), 32'h0);
      chk("se_queue_drained", 32'(se_q.size()), 32'h0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
